// File: rtl/aq_vfmau_frac_mult_pipe.sv
// Lane-splittable significand multiplier for the VFMAU: one double, two single or
// four half/bf16 significand products per issue, delivered LAT cycles after accept.
module aq_vfmau_frac_mult_pipe #(
    parameter int unsigned LAT  = 2,
    parameter int unsigned ID_W = 2
) (
    input  logic            forever_cpuclk,
    input  logic            cpurst_b,
    input  logic            in_vld,
    input  logic [1:0]      in_fmt,
    input  logic [3:0]      in_lane_en,
    input  logic [63:0]     in_srcv0,
    input  logic [63:0]     in_srcv1,
    input  logic [ID_W-1:0] in_id,
    input  logic            pipe_stall,
    input  logic            flush,
    output logic            out_vld,
    output logic [1:0]      out_fmt,
    output logic [105:0]    out_prod,
    output logic [ID_W-1:0] out_id
);

    logic [105:0] dbl_a;
    logic [105:0] dbl_b;
    logic [105:0] dbl_p;
    logic [47:0]  sgl_p [2];
    logic [21:0]  hlf_p [4];
    logic [15:0]  bf_p  [4];
    logic [105:0] prod_c;

    // Sign bits never reach the significand datapath.
    logic unused_sign;
    assign unused_sign = ^{in_srcv0[63], in_srcv0[47], in_srcv0[31], in_srcv0[15],
                           in_srcv1[63], in_srcv1[47], in_srcv1[31], in_srcv1[15]};

    // Hidden bit is set for any nonzero exponent, including all-ones.
    assign dbl_a = {53'd0, |in_srcv0[62:52], in_srcv0[51:0]};
    assign dbl_b = {53'd0, |in_srcv1[62:52], in_srcv1[51:0]};
    assign dbl_p = in_lane_en[0] ? dbl_a * dbl_b : '0;

    for (genvar g = 0; g < 2; g++) begin : g_sgl
        logic [47:0] ma;
        logic [47:0] mb;
        assign ma       = {24'd0, |in_srcv0[32*g+23 +: 8], in_srcv0[32*g +: 23]};
        assign mb       = {24'd0, |in_srcv1[32*g+23 +: 8], in_srcv1[32*g +: 23]};
        assign sgl_p[g] = in_lane_en[g] ? ma * mb : '0;
    end

    for (genvar g = 0; g < 4; g++) begin : g_hb
        logic [21:0] ha;
        logic [21:0] hb;
        logic [15:0] ba;
        logic [15:0] bb;
        assign ha       = {11'd0, |in_srcv0[16*g+10 +: 5], in_srcv0[16*g +: 10]};
        assign hb       = {11'd0, |in_srcv1[16*g+10 +: 5], in_srcv1[16*g +: 10]};
        assign ba       = {8'd0, |in_srcv0[16*g+7 +: 8], in_srcv0[16*g +: 7]};
        assign bb       = {8'd0, |in_srcv1[16*g+7 +: 8], in_srcv1[16*g +: 7]};
        assign hlf_p[g] = in_lane_en[g] ? ha * hb : '0;
        assign bf_p[g]  = in_lane_en[g] ? ba * bb : '0;
    end

    always_comb begin
        prod_c = '0;
        case (in_fmt)
            2'b00:   prod_c = dbl_p;
            2'b01:   prod_c = {10'd0, sgl_p[1], sgl_p[0]};
            2'b10:   prod_c = {18'd0, hlf_p[3], hlf_p[2], hlf_p[1], hlf_p[0]};
            default: prod_c = {18'd0, 6'd0, bf_p[3], 6'd0, bf_p[2], 6'd0, bf_p[1], 6'd0, bf_p[0]};
        endcase
    end

    logic            vld_pipe  [LAT];
    logic [1:0]      fmt_pipe  [LAT];
    logic [105:0]    prod_pipe [LAT];
    logic [ID_W-1:0] id_pipe   [LAT];

    for (genvar s = 0; s < LAT; s++) begin : g_stage
        logic            src_vld;
        logic [1:0]      src_fmt;
        logic [105:0]    src_prod;
        logic [ID_W-1:0] src_id;
        logic            vld_d;
        logic            vld_q;
        logic [1:0]      fmt_d;
        logic [1:0]      fmt_q;
        logic [105:0]    prod_d;
        logic [105:0]    prod_q;
        logic [ID_W-1:0] id_d;
        logic [ID_W-1:0] id_q;

        if (s == 0) begin : g_src
            assign src_vld  = in_vld;
            assign src_fmt  = in_fmt;
            assign src_prod = prod_c;
            assign src_id   = in_id;
        end else begin : g_src
            assign src_vld  = vld_pipe[s-1];
            assign src_fmt  = fmt_pipe[s-1];
            assign src_prod = prod_pipe[s-1];
            assign src_id   = id_pipe[s-1];
        end

        // Flush beats stall; data only moves with a valid op so outputs hold when idle.
        always_comb begin
            vld_d  = vld_q;
            fmt_d  = fmt_q;
            prod_d = prod_q;
            id_d   = id_q;
            if (flush) begin
                vld_d = 1'b0;
            end else if (!pipe_stall) begin
                vld_d = src_vld;
                if (src_vld) begin
                    fmt_d  = src_fmt;
                    prod_d = src_prod;
                    id_d   = src_id;
                end
            end
        end

        always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
            if (!cpurst_b) begin
                vld_q  <= 1'b0;
                fmt_q  <= '0;
                prod_q <= '0;
                id_q   <= '0;
            end else begin
                vld_q  <= vld_d;
                fmt_q  <= fmt_d;
                prod_q <= prod_d;
                id_q   <= id_d;
            end
        end

        assign vld_pipe[s]  = vld_q;
        assign fmt_pipe[s]  = fmt_q;
        assign prod_pipe[s] = prod_q;
        assign id_pipe[s]   = id_q;
    end

    assign out_vld  = vld_pipe[LAT-1];
    assign out_fmt  = fmt_pipe[LAT-1];
    assign out_prod = prod_pipe[LAT-1];
    assign out_id   = id_pipe[LAT-1];

endmodule

// File: doc/aq_vfmau_frac_mult_pipe.md
Name: aq_vfmau_frac_mult_pipe

Overview:
Parametrised, lane-splittable significand multiplier pipeline for the VFMAU. It unpacks hidden bits per format, forms one double, two single, or four half/bf16 significand products per issue, and delivers them after LAT cycles. Pipeline advance is controlled by a global stall and a flush. It replaces the fixed single-stage fraction multiplier that feeds the mult_double/SIMD datapaths in EX2.

Parameters:
LAT, 2, pipeline latency in cycles from accept to out_vld; legal 1..4.
ID_W, 2, width of the sideband tag carried with each operation.

Ports:
forever_cpuclk  input  1  free-running clock
cpurst_b  input  1  asynchronous active-low reset
in_vld  input  1  operation offered this cycle
in_fmt  input  2  00 double, 01 single, 10 half (f16), 11 bf16
in_lane_en  input  4  per-lane enable; double uses bit0; single uses bits 1:0
in_srcv0  input  64  operand A, packed IEEE lanes (lane0 in LSBs)
in_srcv1  input  64  operand B, same packing
in_id  input  ID_W  tag returned with result
pipe_stall  input  1  freeze every stage
flush  input  1  kill all in-flight operations
out_vld  output  1  result valid
out_fmt  output  2  format of result
out_prod  output  106  packed products
out_id  output  ID_W  tag of result

Behaviour:
- Reset (cpurst_b low, async): all stage valid bits 0. out_vld=0, out_fmt=0, out_prod=0, out_id=0. Reset mid-operation discards all in-flight work.
- Accept: in_vld && !pipe_stall && !flush. Upstream holds in_vld/data while stalled; in_vld is ignored during stall.
- Latency: an op accepted in cycle N gives out_vld=1 in cycle N+LAT, assuming no stall cycles in between. Each stall cycle adds one cycle. Throughput is 1 op per cycle.
- Stall: all valid bits, data, and outputs hold. out_vld stays asserted if already set; the same result is presented again.
- Flush: synchronous, highest priority over stall and accept. Next cycle, every valid bit (including out_vld) is 0 and the input is not taken. Data registers need not clear.
- Data registers load only when a valid op advances into them. When out_vld=0, out_prod keeps its last value.
- Significand extraction: hidden bit = (exponent != 0). Exponent all-ones is still treated as hidden=1; special cases are handled downstream.
  - double: 53b = {hid, [51:0]}; exp = [62:52].
  - single lane i (base 32i): 24b; exp = [30:23].
  - half lane i (base 16i): 11b; exp = [14:10].
  - bf16 lane i: 8b; exp = [14:7].
- Product packing:
  - double: out_prod[105:0] = 53x53 product.
  - single: lane i at [48i+47:48i]; bits [105:96] = 0.
  - half: 22-bit product of lane i at [22i+21:22i].
  - bf16: 16-bit product of lane i zero-extended into the same 22-bit slot.
  - All unused bits = 0.
- A disabled lane (in_lane_en bit 0) produces zero in its slot. For double, lane_en[0]=0 gives an all-zero product.
- Pipeline cut: arithmetic may be split across stages (e.g. partial-product tree in stage 1, final add in the last stage). The result must equal the exact unsigned product for every LAT value.
- LAT=1: result is registered once, so out_vld arrives on the cycle after accept.

Test Plan:
- Double, LAT=2: in_srcv0=in_srcv1=0x3FF0000000000000, lane_en=0001, id=1 → two cycles later out_vld=1, out_prod=1<<104, out_id=1, out_fmt=00.
- Single: both operands 0x3F800000_40000000 (lane1=1.0, lane0=2.0) → lane0 slot = 0x400000000000, lane1 slot = 0x400000000000, bits [105:96]=0.
- Half/bf16 with denormal and lane mask:
  - half: A=0x3C00_3C00_0001_3C00, B=0x3C00 in every lane, lane_en=1011 → lane0=0x100000, lane1=0x400, lane2=0, lane3=0x100000.
  - bf16: 0x3F80 x 0x3F80 → 0x4000 per lane.
- Back-to-back: issue 4 ops in consecutive cycles with id 0..3 → out_vld high for 4 consecutive cycles with ids in order 0,1,2,3 and correct products.
- Stall: assert pipe_stall for 3 cycles while 2 ops are in flight → no out change during the stall. The results then appear 3 cycles late with data unchanged, and the held input is accepted exactly once.
- Flush and reset: flush together with in_vld and pipe_stall while 2 ops are in flight → out_vld=0 on every following cycle until a new issue, and the flushed input is not accepted. Drop cpurst_b mid-flight → all outputs 0 at once, no result emerges afterwards.
